// File: rtl/rf_read_stage.sv
// Register-read stage: 32x64 regfile with write-back bypass, load-use hazard
// detection, and the execute-stage pipeline register with flush/stall/bubble control.

module rf_rd_port #(
  parameter int XLEN = 64
) (
  input  logic [4:0]      i_idx,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [XLEN-1:0] i_rf_data,
  output logic [XLEN-1:0] o_val
);
  // idx!=0 already excludes a bypass from wb_rd=0
  always_comb begin
    o_val = i_rf_data;
    if (i_idx == 5'd0)                      o_val = '0;
    else if (i_wb_en && (i_wb_rd == i_idx)) o_val = i_wb_data;
  end
endmodule

module rf_read_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  input  logic [4:0]      rd_idx,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [5:0]      shamt_in,
  input  logic [6:0]      opcode_in,
  input  logic [7:0]      instrId_in,
  input  logic            branch_in,
  input  logic            regw_in,
  input  logic            memr_in,
  input  logic            memw_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            stall_o,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [5:0]      ex_shamt,
  output logic [6:0]      ex_opcode,
  output logic [7:0]      ex_instrId,
  output logic            ex_branch,
  output logic            ex_regw,
  output logic            ex_memr,
  output logic            ex_memw
);
  localparam int NPORT = 2;

  logic [XLEN-1:0] r_rf [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  logic [NPORT-1:0][4:0]      w_idx;
  logic [NPORT-1:0][XLEN-1:0] w_rf_val;
  logic [NPORT-1:0][XLEN-1:0] w_val;

  assign w_idx = {rs2_idx, rs1_idx};

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    assign w_rf_val[g] = r_rf[w_idx[g]];
    rf_rd_port #(.XLEN(XLEN)) u_port (
      .i_idx     (w_idx[g]),
      .i_wb_en   (wb_en),
      .i_wb_rd   (wb_rd),
      .i_wb_data (wb_data),
      .i_rf_data (w_rf_val[g]),
      .o_val     (w_val[g])
    );
  end

  // Both sources compared unconditionally; a false hit only costs one bubble
  logic w_hz;
  assign w_hz = in_valid & ex_valid & ex_memr & (ex_rd != 5'd0) &
                ((ex_rd == rs1_idx) | (ex_rd == rs2_idx));
  assign stall_o = ~flush & (ex_stall | w_hz);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_rd      <= '0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_shamt   <= '0;
      ex_opcode  <= '0;
      ex_instrId <= '0;
      ex_branch  <= 1'b0;
      ex_regw    <= 1'b0;
      ex_memr    <= 1'b0;
      ex_memw    <= 1'b0;
    end else if (flush || (!ex_stall && w_hz)) begin
      ex_valid  <= 1'b0;
      ex_branch <= 1'b0;
      ex_regw   <= 1'b0;
      ex_memr   <= 1'b0;
      ex_memw   <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid   <= in_valid;
      ex_rs1_val <= w_val[0];
      ex_rs2_val <= w_val[1];
      ex_rd      <= rd_idx;
      ex_pc      <= pc_in;
      ex_imm     <= imm_in;
      ex_shamt   <= shamt_in;
      ex_opcode  <= opcode_in;
      ex_instrId <= instrId_in;
      ex_branch  <= branch_in & in_valid;
      ex_regw    <= regw_in   & in_valid;
      ex_memr    <= memr_in   & in_valid;
      ex_memw    <= memw_in   & in_valid;
    end
  end
endmodule

// File: tb/tb_rf_read_stage.sv
// Scoreboard bench for rf_read_stage: a spec-level model predicts each cycle's
// ex_* register contents, which are queued and compared one cycle later.
module tb_rf_read_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [63:0] pc_in, imm_in;
  logic [5:0]  shamt_in;
  logic [6:0]  opcode_in;
  logic [7:0]  instrId_in;
  logic        branch_in, regw_in, memr_in, memw_in;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_stall, flush;
  logic        stall_o, ex_valid;
  logic [63:0] ex_rs1_val, ex_rs2_val, ex_pc, ex_imm;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_shamt;
  logic [6:0]  ex_opcode;
  logic [7:0]  ex_instrId;
  logic        ex_branch, ex_regw, ex_memr, ex_memw;

  always #5 clk = ~clk;

  rf_read_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
    .pc_in(pc_in), .imm_in(imm_in), .shamt_in(shamt_in), .opcode_in(opcode_in),
    .instrId_in(instrId_in), .branch_in(branch_in), .regw_in(regw_in),
    .memr_in(memr_in), .memw_in(memw_in),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .stall_o(stall_o),
    .ex_valid(ex_valid), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_shamt(ex_shamt),
    .ex_opcode(ex_opcode), .ex_instrId(ex_instrId), .ex_branch(ex_branch),
    .ex_regw(ex_regw), .ex_memr(ex_memr), .ex_memw(ex_memw)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] rs1, rs2;
    logic [4:0]  rd;
    logic [63:0] pc, imm;
    logic [5:0]  shamt;
    logic [6:0]  opcode;
    logic [7:0]  id;
    logic        br, rw, mr, mw;
  } ex_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] m_rf [32];
  ex_t         m_ex;
  ex_t         sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_opnd(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  task automatic cmp_out(input ex_t e);
    chk("ex_valid",  {63'd0, ex_valid},  {63'd0, e.valid});
    chk("ex_branch", {63'd0, ex_branch}, {63'd0, e.br});
    chk("ex_regw",   {63'd0, ex_regw},   {63'd0, e.rw});
    chk("ex_memr",   {63'd0, ex_memr},   {63'd0, e.mr});
    chk("ex_memw",   {63'd0, ex_memw},   {63'd0, e.mw});
    if (e.valid) begin
      chk("ex_rs1_val", ex_rs1_val, e.rs1);
      chk("ex_rs2_val", ex_rs2_val, e.rs2);
      chk("ex_rd",      {59'd0, ex_rd},      {59'd0, e.rd});
      chk("ex_pc",      ex_pc,  e.pc);
      chk("ex_imm",     ex_imm, e.imm);
      chk("ex_shamt",   {58'd0, ex_shamt},   {58'd0, e.shamt});
      chk("ex_opcode",  {57'd0, ex_opcode},  {57'd0, e.opcode});
      chk("ex_instrId", {56'd0, ex_instrId}, {56'd0, e.id});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    m_ex = '0;
    sb_q.delete();
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic step();
    logic hz, st;
    ex_t  e;
    #1;
    hz = in_valid & m_ex.valid & m_ex.mr & (m_ex.rd != 0) &
         ((m_ex.rd == rs1_idx) | (m_ex.rd == rs2_idx));
    st = ~flush & (ex_stall | hz);
    chk("stall_o", {63'd0, stall_o}, {63'd0, st});
    e = m_ex;
    if (flush || (!ex_stall && hz)) begin
      e.valid = 0; e.br = 0; e.rw = 0; e.mr = 0; e.mw = 0;
    end else if (!ex_stall) begin
      e.valid = in_valid;
      e.rs1 = m_opnd(rs1_idx);  e.rs2 = m_opnd(rs2_idx);
      e.rd = rd_idx;  e.pc = pc_in;  e.imm = imm_in;
      e.shamt = shamt_in;  e.opcode = opcode_in;  e.id = instrId_in;
      e.br = branch_in & in_valid;  e.rw = regw_in & in_valid;
      e.mr = memr_in & in_valid;    e.mw = memw_in & in_valid;
    end
    sb_q.push_back(e);
    if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    m_ex = e;
    @(negedge clk);
    if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else cmp_out(sb_q.pop_front());
  endtask

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic mr);
    in_valid = v;  rs1_idx = r1;  rs2_idx = r2;  rd_idx = rd;  memr_in = mr;
    pc_in = {$urandom, $urandom};  imm_in = {$urandom, $urandom};
    shamt_in = 6'($urandom);  opcode_in = 7'($urandom);  instrId_in = 8'($urandom);
    branch_in = 1'($urandom);  regw_in = 1'($urandom);  memw_in = 1'($urandom);
  endtask

  task automatic side(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                      input logic fl, input logic es);
    wb_en = we;  wb_rd = wr;  wb_data = wd;  flush = fl;  ex_stall = es;
  endtask

  ex_t held;

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    side(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_pc", ex_pc, 64'd0);
    rst = 1'b1;

    // write x5 then read it from the regfile
    set_in(0, 0, 0, 0, 0); side(1, 5, 64'h1234, 0, 0); step();
    set_in(1, 5, 0, 9, 0); side(0, 0, 0, 0, 0); step();
    chk("x5_read", ex_rs1_val, 64'h1234);

    // same-cycle bypass into rs2, then regfile read of x7
    set_in(1, 0, 7, 1, 0); side(1, 7, 64'hDEAD, 0, 0); step();
    chk("x7_bypass", ex_rs2_val, 64'hDEAD);
    set_in(1, 7, 5, 2, 0); side(0, 0, 0, 0, 0); step();
    chk("x7_stored", ex_rs1_val, 64'hDEAD);

    // x0: write ignored, bypass ignored
    set_in(1, 0, 0, 0, 0); side(1, 0, 64'hFF, 0, 0); step();
    chk("x0_bypass", ex_rs1_val, 64'd0);
    set_in(1, 0, 0, 0, 0); side(0, 0, 0, 0, 0); step();
    chk("x0_stored", ex_rs1_val, 64'd0);

    // load-use: one bubble, then the dependent instruction issues
    set_in(1, 1, 2, 3, 1); step();
    set_in(1, 3, 0, 4, 0);
    #1 chk("lu_stall_hi", {63'd0, stall_o}, 64'd1); #1;
    step();
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    #1 chk("lu_stall_lo", {63'd0, stall_o}, 64'd0); #1;
    step();
    chk("lu_issue", {59'd0, ex_rd}, 64'd4);

    // flush beats a hazard
    set_in(1, 0, 0, 6, 1); step();
    set_in(1, 0, 6, 8, 0); side(0, 0, 0, 1, 0);
    #1 chk("fl_stall", {63'd0, stall_o}, 64'd0); #1;
    step();
    chk("fl_memr", {63'd0, ex_memr}, 64'd0);

    // ex_stall held 3 cycles with changing inputs, then release
    set_in(1, 7, 5, 10, 0); side(0, 0, 0, 0, 0); step();
    held = m_ex;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11, 1);
      side(0, 0, 0, 0, 1); step();
    end
    chk("hold_pc", ex_pc, held.pc);
    set_in(1, 5, 7, 12, 0); side(0, 0, 0, 0, 0); step();
    chk("release_rd", {59'd0, ex_rd}, 64'd12);

    // random traffic over a small register window to force collisions
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 2) == 0));
      side(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0));
      step();
    end

    // reset asserted while a load-use stall is pending
    set_in(1, 0, 0, 5, 1); side(1, 5, 64'h55, 0, 0); step();
    set_in(1, 5, 0, 6, 0); side(0, 0, 0, 0, 0);
    #1 chk("mr_stall_pre", {63'd0, stall_o}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_stall", {63'd0, stall_o}, 64'd0);
    chk("mr_valid", {63'd0, ex_valid}, 64'd0);
    chk("mr_pc", ex_pc, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 5, 7, 1, 0); step();
    chk("mr_rf_clear", ex_rs1_val, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rf_read_stage.md
# rf_read_stage

Register-read stage sitting directly downstream of the decode/register-file pipeline register. Holds the 32×64 integer register file, reads both source operands with write-back bypass, and detects load-use hazards. Registers the operands plus decoded fields into the execute-stage pipeline register, with valid, bubble and flush control. It produces the stall that gates the enable of the upstream decode/register-file pipeline register.

## Interface
- XLEN, 64, datapath width
- NREG, 32, architectural registers; x0 reads zero
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream register holds a real instruction
- rs1_idx, rs2_idx, rd_idx  in  5  register indices
- pc_in  in  64  instruction PC
- imm_in  in  64  sign-extended immediate
- shamt_in  in  6; opcode_in  in  7; instrId_in  in  8
- branch_in, regw_in, memr_in, memw_in  in  1  control bits
- wb_en  in  1; wb_rd  in  5; wb_data  in  64  write-back port
- ex_stall  in  1  execute stage cannot accept
- flush  in  1  branch redirect; kill in-flight instruction
- stall_o  out  1  hold upstream register (upstream enable = ~stall_o)
- ex_valid  out  1; ex_rs1_val, ex_rs2_val  out  64
- ex_rd  out  5; ex_pc, ex_imm  out  64; ex_shamt  out  6; ex_opcode  out  7; ex_instrId  out  8
- ex_branch, ex_regw, ex_memr, ex_memw  out  1

## Operation
- Register file: 32 entries × 64 bits. Write on rising clk when wb_en=1 and wb_rd≠0. Writes to x0 are ignored. Writes occur regardless of stall, flush or ex_stall.
- Operand select, per source, in priority order:
  - idx=0 → 0
  - wb_en and wb_rd=idx → wb_data (same-cycle bypass)
  - otherwise the regfile entry
- Load-use hazard: hz = in_valid & ex_valid & ex_memr & ex_rd≠0 & (ex_rd=rs1_idx | ex_rd=rs2_idx). Both sources are always compared, with no per-opcode filtering.
- stall_o = ~flush & (ex_stall | hz). It is combinational.
- Output register update priority at each rising edge:
  1. flush: ex_valid←0, all control bits ←0, other fields unchanged.
  2. ex_stall: hold all outputs.
  3. hz: insert bubble. ex_valid←0, control bits ←0.
  4. otherwise: load ex_valid←in_valid and all fields from the inputs and operand select. Control bits are qualified by in_valid, so they are 0 when in_valid=0.
- States are implicit: RUN, BUBBLE (one cycle of hz), and HOLD (ex_stall). A load-use hazard always resolves after exactly one bubble, because the bubble clears ex_memr.

## Timing
- Reset (rst=0, asynchronous):
  - every output register ←0, including ex_valid=0
  - all 32 regfile entries ←0
  - stall_o evaluates to 0 after reset since ex_valid=0
- Latency: 1 cycle from input to ex_* outputs. A wb write is visible to a same-cycle read via bypass, and via the regfile from the next cycle.
- A load followed by a dependent instruction produces 1 bubble cycle and stall_o high for 1 cycle.
- flush with hz or ex_stall in the same cycle: flush wins and stall_o=0. The upstream register is then also cleared by the flush network.
- Reset asserted mid-stall: outputs clear immediately and stall_o drops without waiting for a clock edge.
- wb_rd=0 with wb_en=1: no write and no bypass. The operand reads 0.

## Test plan
- Reset, then write x5=0x1234 via wb; next cycle issue rs1=5 → after 1 cycle ex_rs1_val=0x1234, ex_valid=1.
- Same-cycle bypass: wb_en=1, wb_rd=7, wb_data=0xDEAD with rs2_idx=7 → ex_rs2_val=0xDEAD next cycle; x7 also holds 0xDEAD afterwards.
- x0 handling: wb_en=1, wb_rd=0, wb_data=0xFF; read rs1=0 → ex_rs1_val=0 in both the bypass and stored cases.
- Load-use: cycle N load with rd=3 (memr=1); cycle N+1 instruction with rs1=3 → stall_o=1 in N+1, ex_valid=0 at N+2, dependent instruction appears at N+3 with stall_o=0.
- Flush priority: hazard condition plus flush=1 → stall_o=0, ex_valid=0 and ex_memr=0 next cycle.
- ex_stall held 3 cycles → stall_o=1 throughout and ex_* held constant; release → the next input loads normally.
